// File: rtl/exec_alu_csr_unit.sv
// Integer execute stage: 64-bit ALU with branch compare and RV64 word ops, plus the
// CSR read-modify-write calculator. Every result is registered on the edge that samples in_valid.
module exec_alu_csr_unit #(
  parameter int XLEN    = 64,
  parameter int IMM_LEN = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [XLEN-1:0]    alu_a,
  input  logic [XLEN-1:0]    alu_b,
  input  logic [4:0]         alu_op,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    csr_data,
  input  logic [IMM_LEN-1:0] imm_csr,
  input  logic               use_imm_csr,
  input  logic [1:0]         csr_op,
  output logic               out_valid,
  output logic [XLEN-1:0]    alu_out,
  output logic               compare_out,
  output logic [XLEN-1:0]    csr_result,
  output logic               csr_valid
);
  // Handshake: valid-only. A beat is taken on every edge with in_valid=1; there is no ready
  // and no stall, so out_valid/csr_valid pulse for exactly one cycle per accepted beat.

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] alu_nxt;
  logic            cmp_nxt;
  logic [XLEN-1:0] csr_src;
  logic [XLEN-1:0] csr_nxt;
  logic [31:0]     word_res;
  logic [SHW-1:0]  shamt;
  logic [4:0]      shamt_w;
  logic            lt_s;
  logic            lt_u;
  logic            unused_imm;

  assign unused_imm = ^imm_csr[IMM_LEN-1:5];

  assign diff    = alu_a - alu_b;
  assign shamt   = alu_b[SHW-1:0];
  assign shamt_w = alu_b[4:0];
  assign lt_s    = $signed(alu_a) < $signed(alu_b);
  assign lt_u    = alu_a < alu_b;

  // Word ops share one 32-bit result that is sign-extended below.
  always_comb begin
    word_res = '0;
    case (alu_op)
      5'd10:   word_res = alu_a[31:0] + alu_b[31:0];
      5'd11:   word_res = alu_a[31:0] - alu_b[31:0];
      5'd12:   word_res = alu_a[31:0] << shamt_w;
      5'd13:   word_res = alu_a[31:0] >> shamt_w;
      5'd14:   word_res = $signed(alu_a[31:0]) >>> shamt_w;
      default: word_res = '0;
    endcase
  end

  always_comb begin
    alu_nxt = '0;
    cmp_nxt = 1'b0;
    case (alu_op)
      5'd0:  alu_nxt = alu_a + alu_b;
      5'd1:  alu_nxt = diff;
      5'd2:  alu_nxt = alu_a << shamt;
      5'd3:  alu_nxt = alu_a >> shamt;
      5'd4:  alu_nxt = $signed(alu_a) >>> shamt;
      5'd5:  alu_nxt = {{(XLEN-1){1'b0}}, lt_s};
      5'd6:  alu_nxt = {{(XLEN-1){1'b0}}, lt_u};
      5'd7:  alu_nxt = alu_a ^ alu_b;
      5'd8:  alu_nxt = alu_a | alu_b;
      5'd9:  alu_nxt = alu_a & alu_b;
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14:
             alu_nxt = {{(XLEN-32){word_res[31]}}, word_res};
      5'd15: begin alu_nxt = diff; cmp_nxt = (alu_a == alu_b); end
      5'd16: begin alu_nxt = diff; cmp_nxt = (alu_a != alu_b); end
      5'd17: begin alu_nxt = diff; cmp_nxt = lt_s;             end
      5'd18: begin alu_nxt = diff; cmp_nxt = ~lt_s;            end
      5'd19: begin alu_nxt = diff; cmp_nxt = lt_u;             end
      5'd20: begin alu_nxt = diff; cmp_nxt = ~lt_u;            end
      5'd21: alu_nxt = alu_b;
      default: alu_nxt = '0;
    endcase
  end

  assign csr_src = use_imm_csr ? {{(XLEN-5){1'b0}}, imm_csr[4:0]} : rs1_data;

  always_comb begin
    csr_nxt = '0;
    case (csr_op)
      2'd1:    csr_nxt = csr_src;
      2'd2:    csr_nxt = csr_data | csr_src;
      2'd3:    csr_nxt = csr_data & ~csr_src;
      default: csr_nxt = '0;
    endcase
  end

  // Data outputs hold between beats; only the strobes drop on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      csr_valid   <= 1'b0;
      alu_out     <= '0;
      compare_out <= 1'b0;
      csr_result  <= '0;
    end else if (in_valid) begin
      out_valid   <= 1'b1;
      csr_valid   <= (csr_op != 2'd0);
      alu_out     <= alu_nxt;
      compare_out <= cmp_nxt;
      csr_result  <= csr_nxt;
    end else begin
      out_valid   <= 1'b0;
      csr_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_alu_csr_unit.sv
// Bench for exec_alu_csr_unit: directed cases from the test plan, an async reset pulse,
// then randomized beats scored against a behavioural model through an expected queue.
module tb_exec_alu_csr_unit;
  localparam int XLEN = 64;
  localparam int EW   = 2 * XLEN + 3;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [63:0]     alu_a, alu_b, rs1_data, csr_data, imm_csr;
  logic [4:0]      alu_op;
  logic            use_imm_csr;
  logic [1:0]      csr_op;
  logic            out_valid, compare_out, csr_valid;
  logic [63:0]     alu_out, csr_result;

  // Expected entry: {out_valid, csr_valid, compare_out, csr_result, alu_out}
  logic [EW-1:0]   exp_q[$];
  logic [63:0]     held_alu, held_csr;
  logic            held_cmp;
  int              checks, errors;

  exec_alu_csr_unit #(.XLEN(64), .IMM_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .rs1_data(rs1_data), .csr_data(csr_data), .imm_csr(imm_csr),
    .use_imm_csr(use_imm_csr), .csr_op(csr_op),
    .out_valid(out_valid), .alu_out(alu_out), .compare_out(compare_out),
    .csr_result(csr_result), .csr_valid(csr_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference model: RISC-V semantics via signed/unsigned integer arithmetic.
  function automatic logic [63:0] ref_alu(input int op, input logic [63:0] a, input logic [63:0] b,
                                          output logic cmp);
    longint          sa = longint'(a);
    longint          sb = longint'(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    int              sh = int'(b[5:0]);
    int              sh5 = int'(b[4:0]);
    int              w;
    int unsigned     uw;
    logic [63:0]     r;
    cmp = 1'b0;
    r   = 64'd0;
    case (op)
      0: r = ua + ub;
      1: r = ua - ub;
      2: r = ua * (64'd1 << sh);
      3: r = ua / (64'd1 << sh);
      4: begin
        r = ua >> sh;
        if (sa < 0 && sh != 0) r = r | ~(64'hFFFF_FFFF_FFFF_FFFF >> sh);
      end
      5: r = (sa < sb) ? 64'd1 : 64'd0;
      6: r = (ua < ub) ? 64'd1 : 64'd0;
      7: r = a ^ b;
      8: r = a | b;
      9: r = a & b;
      10: begin w = int'(a[31:0]) + int'(b[31:0]); r = longint'(w); end
      11: begin w = int'(a[31:0]) - int'(b[31:0]); r = longint'(w); end
      12: begin uw = a[31:0] * (32'd1 << sh5); r = longint'(int'(uw)); end
      13: begin uw = a[31:0] / (32'd1 << sh5); r = longint'(int'(uw)); end
      14: begin w = int'(a[31:0]) >>> sh5; r = longint'(w); end
      15: begin r = ua - ub; cmp = (a == b); end
      16: begin r = ua - ub; cmp = (a != b); end
      17: begin r = ua - ub; cmp = (sa < sb); end
      18: begin r = ua - ub; cmp = (sa >= sb); end
      19: begin r = ua - ub; cmp = (ua < ub); end
      20: begin r = ua - ub; cmp = (ua >= ub); end
      21: r = b;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] ref_csr(input int op, input logic [63:0] cur, input logic [63:0] rs1,
                                          input logic [63:0] imm, input logic use_imm);
    logic [63:0] src = use_imm ? (imm % 64'd32) : rs1;
    case (op)
      1: return src;
      2: return cur | src;
      3: return cur & ~src;
      default: return 64'd0;
    endcase
  endfunction

  // Scoreboard: compare the DUT against the head of exp_q
  task automatic score();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check("out_valid",   {63'd0, out_valid},   {63'd0, e[EW-1]});
    check("csr_valid",   {63'd0, csr_valid},   {63'd0, e[EW-2]});
    check("compare_out", {63'd0, compare_out}, {63'd0, e[EW-3]});
    check("csr_result",  csr_result, e[127:64]);
    check("alu_out",     alu_out,    e[63:0]);
  endtask

  // Driver: one beat (valid or idle), sampled 1 time unit after the capturing edge
  task automatic drive(input logic v, input int op, input logic [63:0] a, input logic [63:0] b,
                       input int cop, input logic [63:0] rs1, input logic [63:0] cur,
                       input logic [63:0] imm, input logic ui);
    logic c;
    logic [63:0] r;
    @(negedge clk);
    in_valid = v; alu_op = 5'(op); alu_a = a; alu_b = b;
    csr_op = 2'(cop); rs1_data = rs1; csr_data = cur; imm_csr = imm; use_imm_csr = ui;
    if (v) begin
      r = ref_alu(op, a, b, c);
      held_alu = r;
      held_cmp = c;
      held_csr = ref_csr(cop, cur, rs1, imm, ui);
    end
    exp_q.push_back({v, v && (cop != 0), held_cmp, held_csr, held_alu});
    @(posedge clk);
    #1;
    score();
  endtask

  task automatic alu_beat(input int op, input logic [63:0] a, input logic [63:0] b);
    drive(1'b1, op, a, b, 0, 64'd0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic csr_beat(input int cop, input logic [63:0] rs1, input logic [63:0] cur,
                          input logic [63:0] imm, input logic ui);
    drive(1'b1, 0, 64'd0, 64'd0, cop, rs1, cur, imm, ui);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ov"},  {63'd0, out_valid},   64'd0);
    check({tag, "_cv"},  {63'd0, csr_valid},   64'd0);
    check({tag, "_cmp"}, {63'd0, compare_out}, 64'd0);
    check({tag, "_alu"}, alu_out,    64'd0);
    check({tag, "_csr"}, csr_result, 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    held_alu = '0; held_csr = '0; held_cmp = 1'b0;
    in_valid = 0; alu_a = '0; alu_b = '0; alu_op = '0; rs1_data = '0; csr_data = '0;
    imm_csr = '0; use_imm_csr = 0; csr_op = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1;

    // Directed cases with hand-derived values
    alu_beat(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("add_wrap", alu_out, 64'd0);
    check("add_wrap_valid", {63'd0, out_valid}, 64'd1);
    alu_beat(10, 64'h7FFF_FFFF, 64'd1);
    check("addw_ovf", alu_out, 64'hFFFF_FFFF_8000_0000);
    alu_beat(14, 64'h8000_0000, 64'd4);
    check("sraw", alu_out, 64'hFFFF_FFFF_F800_0000);
    alu_beat(4, 64'h8000_0000_0000_0000, 64'd63);
    check("sra63", alu_out, 64'hFFFF_FFFF_FFFF_FFFF);
    alu_beat(17, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("blt", {63'd0, compare_out}, 64'd1);
    alu_beat(19, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("bltu", {63'd0, compare_out}, 64'd0);
    csr_beat(3, 64'h08, 64'h88, 64'd0, 1'b0);
    check("csr_rc", csr_result, 64'h80);
    check("csr_rc_v", {63'd0, csr_valid}, 64'd1);
    csr_beat(2, 64'hFFFF, 64'd0, 64'h3F, 1'b1);
    check("csr_rs_imm", csr_result, 64'h1F);
    csr_beat(2, 64'd0, 64'h55, 64'd0, 1'b1);
    check("csr_rs_zero_v", {63'd0, csr_valid}, 64'd1);
    drive(1'b0, 7, 64'd5, 64'd6, 1, 64'd9, 64'd0, 64'd0, 1'b0);

    // Async reset pulse between two valid ops
    alu_beat(21, 64'd0, 64'h1234_5000);
    #2;
    rst_n = 0;
    #1;
    check_all_zero("async_rst");
    held_alu = '0; held_csr = '0; held_cmp = 1'b0;
    @(negedge clk);
    rst_n = 1;
    alu_beat(1, 64'd10, 64'd3);
    check("post_rst_sub", alu_out, 64'd7);
    check("post_rst_ov", {63'd0, out_valid}, 64'd1);

    // Randomized beats, mixing idles, operand reuse and small shift amounts
    for (int i = 0; i < 400; i++) begin
      logic [63:0] a, b, rs1, cur, imm;
      a   = {$urandom, $urandom};
      b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 70));
      rs1 = {$urandom, $urandom};
      cur = {$urandom, $urandom};
      imm = {$urandom, $urandom};
      drive($urandom_range(0, 4) != 0, int'($urandom_range(0, 31)), a, b,
            int'($urandom_range(0, 3)), rs1, cur, imm, 1'($urandom_range(0, 1)));
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
